alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised, registered multi-cycle ALU; next generation of the team's 32-bit combinational ALU.
- Keeps the eight logic/add/sub operations and the NZCV flag semantics.
- Adds iterative shifts and an iterative unsigned multiply.
- Adds a start/busy/done handshake and registered result/flag outputs.
- Sits between an operand register file and a sequencing controller that issues one operation at a time.

Parameters:
- WIDTH, 32: operand/result width in bits. Legal range 4..64.
- SAW, $clog2(WIDTH): shift-amount width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  4  operation code
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result and flags updated
- result  output  WIDTH  registered result
- c  output  1  carry flag
- n  output  1  negative flag
- z  output  1  zero flag
- v  output  1  overflow flag

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, c=n=z=v=0.
  - Reset mid-operation aborts it; no done is produced.
- States:
  - IDLE: start=1 at edge T0 latches op, a, b and sets cnt=k; busy=1; go to RUN.
  - RUN: while cnt!=0, perform one iteration and decrement cnt. When cnt==0, write result and flags, pulse done, clear busy, go to IDLE.
- Latency:
  - result, flags and done=1 become visible after edge T0+1+k; busy falls at that same edge.
  - k=0 for op 0-7 and 12-15.
  - k=b[SAW-1:0] for op 8-10 (one bit per cycle).
  - k=WIDTH for op 11.
- Handshake:
  - start is ignored while busy=1.
  - start held high in the done cycle is accepted, giving back-to-back operations.
  - done is high for exactly one cycle.
  - result and flags hold their value until the next done.
  - Operand inputs may change after T0 without effect.
- Operations (results are modulo 2^WIDTH):
  - 0: ~a
  - 1: ~b
  - 2: a&b
  - 3: a|b
  - 4: a^b
  - 5: ~(a^b)
  - 6: a+b
  - 7: a+~b+1
  - 8: SLL a by b[SAW-1:0]
  - 9: SRL
  - 10: SRA, sign bit replicated
  - 11: unsigned a*b by shift-add; result = low WIDTH bits of the 2*WIDTH product
  - 12-15: reserved; result=0
- Flags (written only at done):
  - All ops: n=result[WIDTH-1]; z=(result==0).
  - op 6/7: c = adder carry-out (for SUB, c=1 means no borrow); v = signed overflow = carry into MSB XOR carry out of MSB.
  - op 0-5 and 12-15: c=v=0.
  - op 8-10: c = last bit shifted out (0 when amount=0); v=0.
  - op 11: c = v = (upper WIDTH bits of product != 0).
- Boundary conditions:
  - Shift amount 0 gives result=a, latency 1.
  - Shift amount WIDTH-1 gives the maximum shift latency.
  - b bits above SAW are ignored for shifts.
  - Multiply by 0 still takes WIDTH+1 cycles.
  - Iterative datapath registers are internal; result does not change during RUN.

Test Plan:
- WIDTH=32: reset, then start op=6, a=32'hFFFF_FFFF, b=1 → after 1 cycle: done=1, result=0, c=1, z=1, n=0, v=0.
- op=7, a=32'h8000_0000, b=1 → result=32'h7FFF_FFFF, v=1, c=1, n=0. Then op=7, a=0, b=1 → result=32'hFFFF_FFFF, c=0, n=1.
- op=10, a=32'h8000_00F0, b=4 → busy for 5 cycles, then done: result=32'hF800_000F, c=0. Same with op=9 → result=32'h0800_000F. Same with b=0 → latency 1, result=a, c=0.
- op=11, a=32'h0001_0000, b=32'h0001_0000 → done after 33 cycles, result=0, z=1, c=v=1. Then a=12345, b=678 → result=8369910, c=0.
- Handshake: start held continuously across two op=2 requests → two done pulses on consecutive accepts. Start pulsed during a multiply → ignored, one done only. reset_n low mid-multiply → all outputs 0 immediately, no done.
- WIDTH=8 regression: op=8, a=8'h81, b=8'h09 → amount 1, result=8'h02, c=1. op=5, a=8'hF0, b=8'h0F → result=0, z=1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with iterative shifts, shift-add multiply and start/busy/done handshake
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v
);
    localparam int SAW = $clog2(WIDTH);
    localparam int CW = SAW + 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, lo, hi, bb, res_nx;
    logic [WIDTH:0]   sum, acc;
    logic [CW-1:0]    cnt;
    logic             sc, c_nx, v_nx, launch, finish;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        launch = 1'b0;
        finish = 1'b0;
        if (state == IDLE && start) begin
            state_nx = RUN;
            launch = 1'b1;
        end else if (state == RUN && cnt == '0) begin
            state_nx = IDLE;
            finish = 1'b1;
        end
    end

    assign busy = state == RUN;

    // lo doubles as the shift register and the low half of the product; hi is the product's upper half
    always_comb begin
        bb = op_r == 4'd7 ? ~b_r : b_r;
        sum = {1'b0, a_r} + {1'b0, bb} + (WIDTH+1)'(op_r == 4'd7);
        acc = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : '0);
        res_nx = '0;
        c_nx = 1'b0;
        v_nx = 1'b0;
        case (op_r)
            4'd0: res_nx = ~a_r;
            4'd1: res_nx = ~b_r;
            4'd2: res_nx = a_r & b_r;
            4'd3: res_nx = a_r | b_r;
            4'd4: res_nx = a_r ^ b_r;
            4'd5: res_nx = ~(a_r ^ b_r);
            4'd6, 4'd7: begin
                res_nx = sum[WIDTH-1:0];
                c_nx = sum[WIDTH];
                v_nx = (a_r[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            4'd8, 4'd9, 4'd10: begin
                res_nx = lo;
                c_nx = sc;
            end
            4'd11: begin
                res_nx = lo;
                c_nx = |hi;
                v_nx = |hi;
            end
            default: res_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            lo <= '0;
            hi <= '0;
            cnt <= '0;
            sc <= 1'b0;
            done <= 1'b0;
            result <= '0;
            c <= 1'b0;
            n <= 1'b0;
            z <= 1'b0;
            v <= 1'b0;
        end else begin
            done <= finish;
            if (launch) begin
                op_r <= op;
                a_r <= a;
                b_r <= b;
                sc <= 1'b0;
                hi <= '0;
                lo <= op == 4'd11 ? b : a;
                cnt <= op == 4'd11 ? CW'(WIDTH) : (op >= 4'd8 && op <= 4'd10) ? CW'(b[SAW-1:0]) : '0;
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - CW'(1);
                case (op_r)
                    4'd8: begin
                        sc <= lo[WIDTH-1];
                        lo <= lo << 1;
                    end
                    4'd9: begin
                        sc <= lo[0];
                        lo <= lo >> 1;
                    end
                    4'd10: begin
                        sc <= lo[0];
                        lo <= {lo[WIDTH-1], lo[WIDTH-1:1]};
                    end
                    4'd11: begin
                        hi <= acc[WIDTH:1];
                        lo <= {acc[0], lo[WIDTH-1:1]};
                    end
                    default: ;
                endcase
            end
            if (finish) begin
                result <= res_nx;
                n <= res_nx[WIDTH-1];
                z <= res_nx == '0;
                c <= c_nx;
                v <= v_nx;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=32 plus a small WIDTH=8 regression
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] a_i = '0, b_i = '0;
    logic        busy, done, c, n, z, v;
    logic [31:0] result;

    logic        st8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, c8, n8, z8, v8;
    logic [7:0]  res8;

    int total = 0, bad = 0, cyc = 0, ndone = 0;
    logic prev_done = 1'b0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] r;
        logic c, n, z, v;
        int lat, t0, op;
    } exp_t;
    exp_t sb[$];

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .result(result), .c(c), .n(n), .z(z), .v(v)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(st8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .c(c8), .n(n8), .z(z8), .v(v8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int sh;
        logic [63:0] p;
        longint d;
        sh = int'(b[4:0]);
        e.c = 1'b0;
        e.v = 1'b0;
        e.lat = 1;
        e.op = int'(op);
        case (op)
            4'd0: e.r = ~a;
            4'd1: e.r = ~b;
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = ~(a ^ b);
            4'd6: begin
                p = {32'b0, a} + {32'b0, b};
                e.r = p[31:0];
                e.c = p[32];
                d = longint'($signed(a)) + longint'($signed(b));
                e.v = d != longint'($signed(e.r));
            end
            4'd7: begin
                e.r = a - b;
                e.c = a >= b;
                d = longint'($signed(a)) - longint'($signed(b));
                e.v = d != longint'($signed(e.r));
            end
            4'd8: begin
                e.r = a << sh;
                e.c = sh != 0 ? a[32-sh] : 1'b0;
                e.lat = sh + 1;
            end
            4'd9, 4'd10: begin
                e.r = op == 4'd9 ? a >> sh : 32'($signed(a) >>> sh);
                e.c = sh != 0 ? a[sh-1] : 1'b0;
                e.lat = sh + 1;
            end
            4'd11: begin
                p = {32'b0, a} * {32'b0, b};
                e.r = p[31:0];
                e.c = |p[63:32];
                e.v = e.c;
                e.lat = 33;
            end
            default: e.r = '0;
        endcase
        e.n = e.r[31];
        e.z = e.r == 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            ndone++;
            check("done_pulse", 64'(prev_done), 64'd0);
            if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("op%0d_res", e.op), 64'(result), 64'(e.r));
                check($sformatf("op%0d_c", e.op), 64'(c), 64'(e.c));
                check($sformatf("op%0d_n", e.op), 64'(n), 64'(e.n));
                check($sformatf("op%0d_z", e.op), 64'(z), 64'(e.z));
                check($sformatf("op%0d_v", e.op), 64'(v), 64'(e.v));
                check($sformatf("op%0d_lat", e.op), 64'(cyc - e.t0), 64'(e.lat));
            end
            last_res = result;
        end else if (busy && reset_n) check("hold_during_run", 64'(result), 64'(last_res));
        prev_done = done;
    end

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        op_i = op;
        a_i = a;
        b_i = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(op, a, b);
        e.t0 = cyc;
        sb.push_back(e);
        a_i = $urandom;
        b_i = $urandom;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b);
        drain();
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic ez, input int lat);
        int t0;
        int k;
        @(negedge clk);
        op8 = op;
        a8 = a;
        b8 = b;
        st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        t0 = cyc;
        k = 0;
        while (!done8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("w8_done", 64'(done8), 64'd1);
        check("w8_lat", 64'(cyc - t0), 64'(lat));
        check("w8_res", 64'(res8), 64'(er));
        check("w8_c", 64'(c8), 64'(ec));
        check("w8_z", 64'(z8), 64'(ez));
    endtask

    initial begin
        int n0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({c, n, z, v}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(4'd6, 32'hFFFF_FFFF, 32'd1);
        run_op(4'd7, 32'h8000_0000, 32'd1);
        run_op(4'd7, 32'd0, 32'd1);
        run_op(4'd6, 32'h7FFF_FFFF, 32'd1);
        run_op(4'd7, 32'd5, 32'd5);
        for (int i = 0; i < 16; i++) begin
            if (i != 11) run_op(4'(i), $urandom, $urandom);
        end
        run_op(4'd10, 32'h8000_00F0, 32'd4);
        run_op(4'd9, 32'h8000_00F0, 32'd4);
        run_op(4'd10, 32'h8000_00F0, 32'd0);
        run_op(4'd8, 32'h8000_0001, 32'd31);
        run_op(4'd10, 32'h8000_0001, 32'd31);
        run_op(4'd9, 32'hDEAD_BEEF, 32'hFFFF_FFE3);
        run_op(4'd8, $urandom, $urandom);
        run_op(4'd11, 32'h0001_0000, 32'h0001_0000);
        run_op(4'd11, 32'd12345, 32'd678);
        run_op(4'd11, $urandom, 32'd0);
        run_op(4'd11, $urandom, $urandom);

        // start pulses during a multiply must be ignored
        n0 = ndone;
        launch(4'd11, 32'd1000, 32'd3000);
        repeat (5) @(negedge clk);
        op_i = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("ignored_start", 64'(ndone - n0), 64'd1);

        // start held across two requests gives back-to-back accepts
        n0 = ndone;
        @(negedge clk);
        op_i = 4'd2;
        a_i = 32'hF0F0_1234;
        b_i = 32'hFF00_FF00;
        start = 1'b1;
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e = model(4'd2, 32'hF0F0_1234, 32'hFF00_FF00);
            e.t0 = cyc;
            sb.push_back(e);
        end
        a_i = 32'h0000_FFFF;
        b_i = 32'h1234_5678;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            exp_t e;
            e = model(4'd2, 32'h0000_FFFF, 32'h1234_5678);
            e.t0 = cyc;
            sb.push_back(e);
        end
        drain();
        repeat (3) @(negedge clk);
        check("b2b_dones", 64'(ndone - n0), 64'd2);

        // reset mid-multiply aborts without done
        run_op(4'd11, 32'd12345, 32'd678);
        launch(4'd11, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        last_res = '0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'({c, n, z, v}), 64'd0);
        n0 = ndone;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(ndone - n0), 64'd0);

        run8(4'd8, 8'h81, 8'h09, 8'h02, 1'b1, 1'b0, 2);
        run8(4'd5, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1);
        run8(4'd11, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 9);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
